// File: rtl/poci_transmitter.sv
// -----------------------------------------------------------------------------
// poci_transmitter
//
// Serialises register-file bytes onto the POCI line, MSB first. A non-zero
// start address launches a burst that walks rd_addr upward and streams one
// byte per eight sclk cycles with no gap between bytes. The burst ends after
// the byte at address 0xFF (pointer wraps to 0x00), or at once on sclk_stop
// or rst.
//
// Ports
//   sclk        in   SPI clock; all state changes on its rising edge
//   rst         in   synchronous active-high reset
//   sclk_stop   in   synchronous transaction abort from the clock comparator
//   addr_valid  in   one-cycle pulse qualifying addr_in
//   addr_in     in   [7:0] burst start address (0x00 is never accepted)
//   rd_data     in   [7:0] register mux data for the current rd_addr
//   rd_addr     out  [7:0] register mux select; next byte to be loaded
//   serial_out  out  registered POCI data bit
//   busy        out  high whenever the FSM is not idle
//   byte_done   out  high on the cycle the last bit of a byte is driven
// -----------------------------------------------------------------------------
module poci_transmitter (
    input  logic       sclk,
    input  logic       rst,
    input  logic       sclk_stop,
    input  logic       addr_valid,
    input  logic [7:0] addr_in,
    input  logic [7:0] rd_data,
    output logic [7:0] rd_addr,
    output logic       serial_out,
    output logic       busy,
    output logic       byte_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_sr;
    logic [7:0] w_sr_next;
    logic [2:0] r_bit_cnt;
    logic [2:0] w_bit_cnt_next;
    logic [7:0] r_rd_addr;
    logic [7:0] w_rd_addr_next;
    logic       r_serial_out;
    logic       w_serial_next;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block is defaulted first so that no path
        // through the case statement leaves a signal unassigned (latch).
        w_next_state   = r_state;
        w_sr_next      = r_sr;
        w_bit_cnt_next = r_bit_cnt;
        w_rd_addr_next = r_rd_addr;

        if (sclk_stop) begin
            // Abort wins over everything except rst; the byte in flight is
            // dropped without a byte_done pulse.
            w_next_state   = ST_IDLE;
            w_sr_next      = 8'h00;
            w_bit_cnt_next = 3'd0;
            w_rd_addr_next = 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (addr_valid && (addr_in != 8'h00)) begin
                        w_rd_addr_next = addr_in;
                        w_next_state   = ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    w_sr_next      = rd_data;
                    w_rd_addr_next = r_rd_addr + 8'd1;
                    w_bit_cnt_next = 3'd7;
                    w_next_state   = ST_SHIFT;
                end

                ST_SHIFT: begin
                    if (r_bit_cnt != 3'd0) begin
                        w_sr_next      = {r_sr[6:0], 1'b0};
                        w_bit_cnt_next = r_bit_cnt - 3'd1;
                    end else if (r_rd_addr != 8'h00) begin
                        // Reload straight from the mux on the last bit so the
                        // next byte's MSB follows with no bubble.
                        w_sr_next      = rd_data;
                        w_rd_addr_next = r_rd_addr + 8'd1;
                        w_bit_cnt_next = 3'd7;
                    end else begin
                        // Pointer wrapped past 0xFF: that byte was the last.
                        w_next_state = ST_IDLE;
                    end
                end

                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end

        // serial_out is a flop loaded with the bit that sr[7] will hold next
        // cycle, so it tracks sr[7] in SHIFT without a combinational path
        // from rd_data to the pin.
        w_serial_next = (w_next_state == ST_SHIFT) ? w_sr_next[7] : 1'b0;
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge sclk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            r_state      <= ST_IDLE;
            r_sr         <= 8'h00;
            r_bit_cnt    <= 3'd0;
            r_rd_addr    <= 8'h00;
            r_serial_out <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_sr         <= w_sr_next;
            r_bit_cnt    <= w_bit_cnt_next;
            r_rd_addr    <= w_rd_addr_next;
            r_serial_out <= w_serial_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (decoded from registers only)
    // -------------------------------------------------------------------------
    assign rd_addr    = r_rd_addr;
    assign serial_out = r_serial_out;
    assign busy       = (r_state != ST_IDLE);
    assign byte_done  = (r_state == ST_SHIFT) && (r_bit_cnt == 3'd0);

endmodule

// File: tb/tb_poci_transmitter.sv
// -----------------------------------------------------------------------------
// tb_poci_transmitter
//
// Drives poci_transmitter through directed scenarios followed by randomized
// bursts. The reference model works at transaction level: when a start
// address is accepted it expands the whole burst into a queue of per-cycle
// expected outputs (one LOAD cycle, then eight bits per byte from the start
// address up to 0xFF). rst and sclk_stop flush the queue.
// -----------------------------------------------------------------------------
module tb_poci_transmitter;

    logic       sclk = 1'b0;
    logic       rst;
    logic       sclk_stop;
    logic       addr_valid;
    logic [7:0] addr_in;
    logic [7:0] rd_data;
    logic [7:0] rd_addr;
    logic       serial_out;
    logic       busy;
    logic       byte_done;

    // Register file seen through the mux, plus optional garbage injection on
    // cycles where the transmitter must not be looking at rd_data.
    logic [7:0] mem [256];
    logic       glitch_en;
    logic [7:0] junk;

    typedef struct packed {
        logic       busy;
        logic       ser;
        logic       bd;
        logic [7:0] ra;
        logic       smp;   // this cycle's rd_data is legitimately sampled
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;

    int checks   = 0;
    int failures = 0;

    poci_transmitter dut (
        .sclk       (sclk),
        .rst        (rst),
        .sclk_stop  (sclk_stop),
        .addr_valid (addr_valid),
        .addr_in    (addr_in),
        .rd_data    (rd_data),
        .rd_addr    (rd_addr),
        .serial_out (serial_out),
        .busy       (busy),
        .byte_done  (byte_done)
    );

    always #5 sclk = ~sclk;

    always_comb begin
        rd_data = mem[rd_addr];
        if (glitch_en && !cur.smp) rd_data = junk;
    end

    function automatic exp_t mk(logic b, logic s, logic d, logic [7:0] a, logic m);
        exp_t e;
        e.busy = b;
        e.ser  = s;
        e.bd   = d;
        e.ra   = a;
        e.smp  = m;
        return e;
    endfunction

    // Expand an accepted burst into per-cycle expectations.
    task automatic build_burst(input logic [7:0] start);
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, start, 1'b1));
        for (int a = int'(start); a < 256; a++) begin
            for (int i = 7; i >= 0; i--) begin
                exp_q.push_back(mk(1'b1, mem[a][i], (i == 0), 8'((a + 1) % 256),
                                   (i == 0) && (a != 255)));
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, expv);
        end
    endtask

    // One sclk edge: advance the model with the inputs present at the edge,
    // then compare all outputs 1 time unit later.
    task automatic tick();
        @(posedge sclk);
        #1;
        if (rst || sclk_stop) begin
            exp_q.delete();
            cur = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        end else if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
        end else if (cur.busy) begin
            cur = mk(1'b0, 1'b0, 1'b0, cur.ra, 1'b0);
        end else if (addr_valid && (addr_in != 8'h00)) begin
            build_burst(addr_in);
            cur = exp_q.pop_front();
        end
        junk = 8'($urandom);
        chk("busy",       {7'd0, busy},       {7'd0, cur.busy});
        chk("serial_out", {7'd0, serial_out}, {7'd0, cur.ser});
        chk("byte_done",  {7'd0, byte_done},  {7'd0, cur.bd});
        chk("rd_addr",    rd_addr,            cur.ra);
    endtask

    initial begin
        rst        = 1'b1;
        sclk_stop  = 1'b0;
        addr_valid = 1'b0;
        addr_in    = 8'h00;
        glitch_en  = 1'b0;
        junk       = 8'h00;
        cur        = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int a = 0; a < 256; a++) mem[a] = 8'(a ^ 8'h3C);
        mem[255] = 8'hA5;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        repeat (2) tick();

        // Zero address is ignored
        addr_valid = 1'b1; addr_in = 8'h00;
        tick();
        addr_valid = 1'b0;
        repeat (3) tick();

        // Single byte from 0xFF (0xA5)
        addr_valid = 1'b1; addr_in = 8'hFF;
        tick();
        addr_valid = 1'b0;
        repeat (12) tick();

        // Burst from 0x10 with addr_valid held high while busy (ignored)
        addr_valid = 1'b1; addr_in = 8'h10;
        tick();
        addr_in = 8'h55;
        repeat (5) tick();
        addr_valid = 1'b0;
        repeat (22) tick();

        // Reset mid-burst with simultaneous addr_valid, then immediate start
        rst = 1'b1; addr_valid = 1'b1; addr_in = 8'h30;
        tick();
        rst = 1'b0;
        tick();
        addr_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1; sclk_stop = 1'b1;
        tick();
        rst = 1'b0; sclk_stop = 1'b0;
        tick();

        // Wrap: 0xFE then 0xFF, then idle at 0x00
        addr_valid = 1'b1; addr_in = 8'hFE;
        tick();
        addr_valid = 1'b0;
        repeat (20) tick();

        // Abort on bit 4 of the first byte, then a clean restart at 0x20
        addr_valid = 1'b1; addr_in = 8'h40;
        tick();
        addr_valid = 1'b0;
        repeat (4) tick();
        sclk_stop = 1'b1;
        tick();
        sclk_stop = 1'b0;
        addr_valid = 1'b1; addr_in = 8'h20;
        tick();
        addr_valid = 1'b0;
        repeat (20) tick();
        sclk_stop = 1'b1;
        tick();
        addr_valid = 1'b1; addr_in = 8'h50;
        tick();
        sclk_stop = 1'b0; addr_valid = 1'b0;
        repeat (2) tick();

        // Randomized bursts with junk on rd_data outside sampling cycles
        glitch_en = 1'b1;
        for (int n = 0; n < 12; n++) begin
            sclk_stop = 1'b1;
            tick();
            sclk_stop = 1'b0;
            for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
            addr_in    = (n % 4 == 0) ? 8'h00 : 8'($urandom_range(255, 224));
            addr_valid = 1'b1;
            tick();
            addr_valid = 1'b0;
            for (int c = 0; c < 300; c++) begin
                addr_valid = cur.busy && ($urandom_range(7, 0) == 0);
                addr_in    = 8'($urandom);
                sclk_stop  = ($urandom_range(199, 0) == 0);
                tick();
                if (!cur.busy) break;
            end
            sclk_stop  = 1'b0;
            addr_valid = 1'b0;
            tick();
        end
        glitch_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
